// File: rtl/bcd_seg_pkg.sv
// Shared constants, FSM state type and sizing helpers
// for the binary-to-BCD seven-segment converter.
package bcd_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ENCODE,
        OUT
    } state_e;

    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

    // True when DIGITS decimal digits can hold every BIN_W-bit value
    function automatic bit digits_fit(input int bin_w, input int digits);
        longint p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p > ((longint'(1) << bin_w) - 1);
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// One BCD nibble to active-high {a,b,c,d,e,f,g} segment code.
// Non-decimal nibbles decode to a blank digit.
module seg7_dec
    import bcd_seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bin2bcd_seg.sv
// Serial double-dabble binary-to-BCD converter with
// seven-segment output, leading-zero blanking and backpressure.
module bin2bcd_seg
    import bcd_seg_pkg::*;
#(
    parameter int BIN_W       = 8,
    parameter int DIGITS      = 3,
    parameter bit SEG_ACT_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_data,
    input  logic                  blank_lz,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = cnt_width(BIN_W);
    localparam logic [7*DIGITS-1:0] SEG_RST = {(7*DIGITS){SEG_ACT_LOW}};

    if (!digits_fit(BIN_W, DIGITS)) begin : g_bad_digits
        $error("bin2bcd_seg: DIGITS too small for BIN_W");
    end

    state_e               state_q;
    logic [SR_W-1:0]      sr_q;
    logic [SR_W-1:0]      sr_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 blank_q;
    logic                 out_valid_q;
    logic [BCD_W-1:0]     bcd_q;
    logic [7*DIGITS-1:0]  seg_q;
    logic [BCD_W-1:0]     bcd_d;
    logic [7*DIGITS-1:0]  seg_raw;
    logic [7*DIGITS-1:0]  seg_d;
    logic                 nz_seen;

    always_comb begin
        sr_d = sr_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (sr_q[BIN_W+4*k +: 4] >= 4'd5) begin
                sr_d[BIN_W+4*k +: 4] = sr_q[BIN_W+4*k +: 4] + 4'd3;
            end
        end
        sr_d = sr_d << 1;
    end

    assign bcd_d = sr_q[SR_W-1 -: BCD_W];

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        seg7_dec u_dec (
            .bcd_i (bcd_d[4*g +: 4]),
            .seg_o (seg_raw[7*g +: 7])
        );
    end

    // Walk from the top digit down; blank zeros until a non-zero appears
    always_comb begin
        seg_d   = seg_raw;
        nz_seen = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (bcd_d[4*k +: 4] != 4'd0) begin
                nz_seen = 1'b1;
            end
            if (blank_q && !nz_seen && k != 0) begin
                seg_d[7*k +: 7] = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            blank_q     <= 1'b0;
            out_valid_q <= 1'b0;
            bcd_q       <= '0;
            seg_q       <= SEG_RST;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sr_q    <= {{BCD_W{1'b0}}, in_data};
                        blank_q <= blank_lz;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BIN_W - 1)) begin
                        state_q <= ENCODE;
                    end
                end
                ENCODE: begin
                    bcd_q   <= bcd_d;
                    seg_q   <= seg_d ^ SEG_RST;
                    state_q <= OUT;
                end
                OUT: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_bin2bcd_seg.sv
// Bench for bin2bcd_seg: default 8-bit/3-digit instance and a
// 16-bit/5-digit active-low instance against a decimal model.
module tb_bin2bcd_seg;

    logic clk;
    logic rst_n;

    logic        a_in_valid;
    logic        a_in_ready;
    logic [7:0]  a_in_data;
    logic        a_blank;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [11:0] a_bcd;
    logic [20:0] a_seg;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [15:0] w_in_data;
    logic        w_blank;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [19:0] w_bcd;
    logic [34:0] w_seg;

    int tests;
    int fails;

    logic [6:0] segtab [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    bin2bcd_seg u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .blank_lz  (a_blank),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .bcd       (a_bcd),
        .seg       (a_seg)
    );

    bin2bcd_seg #(
        .BIN_W       (16),
        .DIGITS      (5),
        .SEG_ACT_LOW (1'b1)
    ) u_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_data   (w_in_data),
        .blank_lz  (w_blank),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .bcd       (w_bcd),
        .seg       (w_seg)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] ref_bcd(input longint v, input int nd);
        logic [19:0] r;
        longint t;
        r = '0;
        t = v;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [34:0] ref_seg(input longint v, input int nd,
                                            input bit blk, input bit inv);
        logic [34:0] r;
        int d [5];
        int top;
        longint t;
        r = '0;
        top = 0;
        t = v;
        for (int k = 0; k < nd; k++) begin
            d[k] = int'(t % 10);
            t = t / 10;
            if (d[k] != 0) top = k;
        end
        for (int k = 0; k < nd; k++) begin
            if (blk && k > top) r[7*k +: 7] = 7'b0000000;
            else                r[7*k +: 7] = segtab[d[k]];
            if (inv) r[7*k +: 7] = ~r[7*k +: 7];
        end
        return r;
    endfunction

    task automatic a_send(input logic [7:0] v, input logic b);
        a_in_valid = 1'b1;
        a_in_data  = v;
        a_blank    = b;
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    task automatic a_wait(output int lat);
        lat = 0;
        while (a_out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic a_pop();
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
    endtask

    task automatic w_send(input logic [15:0] v, input logic b);
        w_in_valid = 1'b1;
        w_in_data  = v;
        w_blank    = b;
        @(negedge clk);
        w_in_valid = 1'b0;
    endtask

    task automatic w_wait(output int lat);
        lat = 0;
        while (w_out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic w_pop();
        w_out_ready = 1'b1;
        @(negedge clk);
        w_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (a_in_ready !== 1'b1) begin
            fails++; $display("FAIL rst_in_ready: got %b want 1", a_in_ready);
        end
        tests++;
        if (a_out_valid !== 1'b0) begin
            fails++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid);
        end
        tests++;
        if (a_bcd !== 12'h000) begin
            fails++; $display("FAIL rst_bcd: got %h want 000", a_bcd);
        end
        tests++;
        if (a_seg !== 21'h0) begin
            fails++; $display("FAIL rst_seg: got %b want 0", a_seg);
        end
        tests++;
        if (w_seg !== {35{1'b1}}) begin
            fails++; $display("FAIL rst_wide_seg: got %b want all ones", w_seg);
        end
        tests++;
        if (w_bcd !== 20'h0 || w_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_wide_bcd: got %h/%b want 0/1", w_bcd, w_in_ready);
        end
    endtask

    task automatic test_convert_0_255();
        int lat;
        a_send(8'd255, 1'b0);
        a_wait(lat);
        tests++;
        if (lat !== 10) begin
            fails++; $display("FAIL lat255: got %0d want 10", lat);
        end
        tests++;
        if (a_bcd !== 12'h255) begin
            fails++; $display("FAIL bcd255: got %h want 255", a_bcd);
        end
        tests++;
        if (a_seg !== 21'b1101101_1011011_1011011) begin
            fails++; $display("FAIL seg255: got %b", a_seg);
        end
        a_pop();
        tests++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL pop255: got valid=%b ready=%b want 0/1",
                     a_out_valid, a_in_ready);
        end
        a_send(8'd0, 1'b0);
        a_wait(lat);
        tests++;
        if (lat !== 10) begin
            fails++; $display("FAIL lat0: got %0d want 10", lat);
        end
        tests++;
        if (a_bcd !== 12'h000) begin
            fails++; $display("FAIL bcd0: got %h want 000", a_bcd);
        end
        tests++;
        if (a_seg !== {3{7'b1111110}}) begin
            fails++; $display("FAIL seg0: got %b", a_seg);
        end
        a_pop();
    endtask

    task automatic test_blanking();
        int lat;
        a_send(8'd7, 1'b1);
        a_wait(lat);
        tests++;
        if (a_bcd !== 12'h007) begin
            fails++; $display("FAIL bcd7: got %h want 007", a_bcd);
        end
        tests++;
        if (a_seg !== {14'b0, 7'b1110000}) begin
            fails++; $display("FAIL seg7blank: got %b", a_seg);
        end
        a_pop();
        a_send(8'd40, 1'b1);
        a_wait(lat);
        tests++;
        if (a_seg !== {7'b0000000, 7'b0110011, 7'b1111110}) begin
            fails++; $display("FAIL seg40blank: got %b", a_seg);
        end
        tests++;
        if (a_bcd !== 12'h040) begin
            fails++; $display("FAIL bcd40: got %h want 040", a_bcd);
        end
        a_pop();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [34:0] e;
        e = ref_seg(123, 3, 1'b0, 1'b0);
        a_send(8'd123, 1'b0);
        a_wait(lat);
        for (int i = 0; i < 20; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'($urandom);
            a_blank    = 1'($urandom);
            @(negedge clk);
            tests++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 ||
                a_bcd !== 12'h123 || a_seg !== e[20:0]) begin
                fails++;
                $display("FAIL hold%0d: got v=%b r=%b bcd=%h seg=%b want 1/0/123/%b",
                         i, a_out_valid, a_in_ready, a_bcd, a_seg, e[20:0]);
            end
        end
        a_in_valid = 1'b0;
        a_pop();
        tests++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL release: got valid=%b ready=%b want 0/1",
                     a_out_valid, a_in_ready);
        end
        tests++;
        if (a_bcd !== 12'h123 || a_seg !== e[20:0]) begin
            fails++; $display("FAIL retain: got bcd=%h want 123", a_bcd);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        a_send(8'd200, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 ||
            a_bcd !== 12'h000 || a_seg !== 21'h0) begin
            fails++;
            $display("FAIL midrst: got v=%b r=%b bcd=%h seg=%b",
                     a_out_valid, a_in_ready, a_bcd, a_seg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_send(8'd13, 1'b0);
        a_wait(lat);
        tests++;
        if (lat !== 10 || a_bcd !== 12'h013) begin
            fails++; $display("FAIL after_rst: got lat=%0d bcd=%h want 10/013", lat, a_bcd);
        end
        a_pop();
    endtask

    task automatic test_wide();
        int lat;
        logic [34:0] e;
        longint vals [3] = '{65535, 10000, 42};
        bit blks [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            w_send(16'(vals[i]), blks[i]);
            w_wait(lat);
            e = ref_seg(vals[i], 5, blks[i], 1'b1);
            tests++;
            if (lat !== 18) begin
                fails++; $display("FAIL wide_lat%0d: got %0d want 18", i, lat);
            end
            tests++;
            if (w_bcd !== ref_bcd(vals[i], 5)) begin
                fails++;
                $display("FAIL wide_bcd%0d: got %h want %h", i, w_bcd, ref_bcd(vals[i], 5));
            end
            tests++;
            if (w_seg !== e) begin
                fails++; $display("FAIL wide_seg%0d: got %b want %b", i, w_seg, e);
            end
            w_pop();
        end
    endtask

    task automatic test_random_sweep();
        int lat;
        int n;
        bit b;
        logic [34:0] e;
        logic [19:0] eb;
        for (int v = 0; v < 256; v++) begin
            b = 1'($urandom);
            a_send(8'(v), b);
            a_wait(lat);
            eb = ref_bcd(v, 3);
            e  = ref_seg(v, 3, b, 1'b0);
            tests++;
            if (lat !== 10 || a_bcd !== eb[11:0]) begin
                fails++;
                $display("FAIL sweep_bcd v=%0d: got lat=%0d bcd=%h want 10/%h",
                         v, lat, a_bcd, eb[11:0]);
            end
            tests++;
            if (a_seg !== e[20:0]) begin
                fails++;
                $display("FAIL sweep_seg v=%0d b=%0d: got %b want %b", v, b, a_seg, e[20:0]);
            end
            n = 0;
            do begin
                a_out_ready = 1'($urandom);
                @(negedge clk);
                n++;
            end while (a_out_valid === 1'b1 && n < 50);
            a_out_ready = 1'b0;
            tests++;
            if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
                fails++;
                $display("FAIL sweep_pop v=%0d: got valid=%b ready=%b want 0/1",
                         v, a_out_valid, a_in_ready);
            end
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        clk         = 1'b0;
        rst_n       = 1'b0;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        a_blank     = 1'b0;
        a_out_ready = 1'b0;
        w_in_valid  = 1'b0;
        w_in_data   = '0;
        w_blank     = 1'b0;
        w_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_convert_0_255();
        test_blanking();
        test_backpressure();
        test_reset_mid();
        test_wide();
        test_random_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seg.md
Name: bin2bcd_seg

Overview:
- Parametrised binary-to-BCD converter with seven-segment encoding for the display path.
- Accepts one BIN_W-bit unsigned value per transaction and converts it serially with shift-add-3 (double dabble), one bit per cycle.
- Presents DIGITS BCD nibbles plus DIGITS seven-segment codes under a valid/ready handshake.
- Generalises the fixed 8-bit/3-digit converter: width, digit count, optional leading-zero blanking, segment polarity and output backpressure.

Parameters:
- BIN_W, 8, width of the binary input.
- DIGITS, 3, number of BCD digits; elaboration error unless 10**DIGITS > 2**BIN_W - 1.
- SEG_ACT_LOW, 0, 1 inverts every segment bit at the output register.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_data  in  BIN_W  unsigned binary value.
- blank_lz  in  1  leading-zero blanking request; sampled with in_data.
- out_valid  out  1  bcd/seg hold a result.
- out_ready  in  1  consumer takes the result.
- bcd  out  4*DIGITS  BCD result; digit 0 (units) in bits [3:0].
- seg  out  7*DIGITS  segment codes; digit k in [7k+6:7k]; bit order {a,b,c,d,e,f,g}, a is MSB.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = IDLE, so in_ready = 1 combinationally.
  - out_valid = 0, bcd = 0, seg = 0 (all 1s when SEG_ACT_LOW = 1).
  - Internal shift register, bit counter and blank flag = 0.
- FSM states: IDLE, SHIFT, ENCODE, OUT.
- IDLE:
  - in_ready = 1.
  - On in_valid: load the shift register {BCD field = 0, binary field = in_data}, latch blank_lz, clear the counter, go to SHIFT.
- SHIFT:
  - Each cycle, add 3 to every BCD nibble that is >= 5 (all nibbles in parallel, combinational), then shift the whole register left by 1.
  - Counter increments each cycle; after the BIN_W-th shift, go to ENCODE.
- ENCODE:
  - Register bcd from the BCD field.
  - Register seg for every digit through seg7_dec.
  - If the latched blank flag is set, every zero digit above the most significant non-zero digit gets SEG_BLANK (0000000). Digit 0 is never blanked.
  - bcd is never blanked.
  - Go to OUT.
- OUT:
  - out_valid = 1.
  - Hold bcd, seg and out_valid stable until out_ready = 1; on that edge drop out_valid and go to IDLE.
- Latency: accept edge T; out_valid is first high after edge T+BIN_W+2. With no backpressure, the next accept is possible at edge T+BIN_W+4.
- in_valid outside IDLE is ignored; no queuing, no error flag.
- in_data and blank_lz changes after acceptance have no effect.
- bcd/seg keep their last value after out_valid falls, until the next ENCODE.
- out_ready while out_valid = 0 has no effect.
- Reset mid-SHIFT or mid-OUT: immediate return to reset values; the partial result is lost.
- Maximum input (all ones) must convert exactly; no overflow is possible given the DIGITS check.
- Segment constants (active high):
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - Nibbles 10-15 are unreachable; decode them to SEG_BLANK.

Decomposition:
- Package bcd_seg_pkg:
  - SEG_0..SEG_9 and SEG_BLANK constants.
  - FSM state enum typedef {IDLE, SHIFT, ENCODE, OUT}.
  - Function computing the counter width, $clog2(BIN_W+1).
- Sub-module seg7_dec: combinational 4-bit BCD to 7-bit segment decoder, instantiated DIGITS times in a generate loop. SEG_ACT_LOW inversion is applied in bin2bcd_seg, not in seg7_dec.
- Add-3 correction and shift stay inline in bin2bcd_seg.

Test Plan:
- Convert 0 and 255: BIN_W=8, DIGITS=3, blank_lz=0; send 255, then 0 -> bcd=0x255, seg={1101101,1011011,1011011}; then bcd=0x000, seg all 1111110; each out_valid appears 10 cycles after its accept edge.
- Leading-zero blanking: blank_lz=1; send 7, then 40 -> for 7, seg = {0000000,0000000,1110000} and bcd=0x007; for 40, hundreds digit blank, tens 0110011, units 1111110.
- Backpressure and ignored input: hold out_ready=0 for 20 cycles with in_valid=1 and changing in_data -> out_valid, bcd and seg stay stable and in_ready=0 throughout; one cycle of out_ready -> out_valid falls and in_ready rises next cycle.
- Reset mid-conversion: accept 200, assert rst_n=0 during cycle 4 of SHIFT -> outputs return to reset values immediately; next accept of 13 yields bcd=0x013 with correct latency.
- Wide instance: BIN_W=16, DIGITS=5, SEG_ACT_LOW=1; send 65535, then 10000 -> bcd=0x65535 with inverted segments; then bcd=0x10000; out_valid 18 cycles after each accept.
- Random sweep: exhaustive 0..255 at BIN_W=8 with random out_ready -> bcd equals the decimal reference model, seg matches the table, no value is lost or duplicated.
